// File: rtl/perf_watchdog_unit.sv
// Run-control and performance-statistics unit: per-channel hit/miss/access/busy
// counters, a commit-aware watchdog, and a halt/timeout end-of-run state machine.
module perf_watchdog_unit #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int WDOG_MODE      = 0,
    localparam int RD_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_access,
    input  logic [NUM_CH-1:0]    ch_hit,
    input  logic [NUM_CH-1:0]    ch_miss,
    input  logic [NUM_CH-1:0]    ch_busy,
    input  logic                 commit_valid,
    input  logic                 halt,
    input  logic                 clear,
    input  logic [RD_W-1:0]      rd_ch,
    input  logic [1:0]           rd_sel,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic [1:0]           state_o,
    output logic                 done_pulse,
    output logic [NUM_CH-1:0]    proto_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HALTED   = 2'd1,
        ST_TIMEDOUT = 2'd2
    } state_e;

    localparam int                 WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]    WD_RELOAD = WD_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [RD_W:0]      NUM_CH_W  = (RD_W + 1)'(NUM_CH);

    // Counter slot order matches the rd_sel encoding: hit, miss, access, busy.
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH][4];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CH][4];
    logic [WD_W-1:0]      wdog_q, wdog_d;
    state_e               state_q, state_d;
    logic                 done_q, done_d;
    logic [NUM_CH-1:0]    protoErr_q, protoErr_d;
    logic [CNT_WIDTH-1:0] rdData_q, rdNext;

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        // A hit+miss collision is a protocol violation whatever the run state.
        protoErr_d = protoErr_q | (ch_hit & ch_miss);
        if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < 4; s++) begin
                    cnt_d[c][s] = '0;
                end
            end
            wdog_d     = WD_RELOAD;
            state_d    = ST_RUN;
            protoErr_d = '0;
        end else if (state_q == ST_RUN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c] && !ch_miss[c] && cnt_q[c][0] != CNT_MAX)
                    cnt_d[c][0] = cnt_q[c][0] + CNT_WIDTH'(1);
                if (ch_miss[c] && !ch_hit[c] && cnt_q[c][1] != CNT_MAX)
                    cnt_d[c][1] = cnt_q[c][1] + CNT_WIDTH'(1);
                if (ch_access[c] && cnt_q[c][2] != CNT_MAX)
                    cnt_d[c][2] = cnt_q[c][2] + CNT_WIDTH'(1);
                if (ch_busy[c] && cnt_q[c][3] != CNT_MAX)
                    cnt_d[c][3] = cnt_q[c][3] + CNT_WIDTH'(1);
            end
            if (WDOG_MODE != 0 && commit_valid)
                wdog_d = WD_RELOAD;
            else
                wdog_d = wdog_q - WD_W'(1);
            if (halt) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
            end else if (wdog_d == '0) begin
                state_d = ST_TIMEDOUT;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        rdNext = '0;
        if ({1'b0, rd_ch} < NUM_CH_W)
            rdNext = cnt_q[rd_ch][rd_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < 4; s++) begin
                    cnt_q[c][s] <= '0;
                end
            end
            wdog_q     <= WD_RELOAD;
            state_q    <= ST_RUN;
            done_q     <= 1'b0;
            protoErr_q <= '0;
            rdData_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wdog_q     <= wdog_d;
            state_q    <= state_d;
            done_q     <= done_d;
            protoErr_q <= protoErr_d;
            rdData_q   <= rdNext;
        end
    end

    assign rd_data    = rdData_q;
    assign state_o    = state_q;
    assign done_pulse = done_q;
    assign proto_err  = protoErr_q;

endmodule

// File: tb/tb_perf_watchdog_unit.sv
// Scoreboard bench: two instances (absolute and commit-relative watchdog) share
// stimulus; a behavioural model predicts every cycle's outputs.
module tb_perf_watchdog_unit;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int TA  = 20;
    localparam int TB  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, clear, halt, commitValid;
    logic [NCH-1:0] chAccess, chHit, chMiss, chBusy;
    logic [1:0]     rdCh, rdSel;

    logic [CW-1:0]  rdDataA, rdDataB;
    logic [1:0]     stateA, stateB;
    logic           doneA, doneB;
    logic [NCH-1:0] perrA, perrB;

    perf_watchdog_unit #(.NUM_CH(NCH), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TA), .WDOG_MODE(0)) dutA (
        .clk(clk), .rst(rst), .ch_access(chAccess), .ch_hit(chHit), .ch_miss(chMiss),
        .ch_busy(chBusy), .commit_valid(commitValid), .halt(halt), .clear(clear),
        .rd_ch(rdCh), .rd_sel(rdSel), .rd_data(rdDataA), .state_o(stateA),
        .done_pulse(doneA), .proto_err(perrA)
    );

    perf_watchdog_unit #(.NUM_CH(NCH), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TB), .WDOG_MODE(1)) dutB (
        .clk(clk), .rst(rst), .ch_access(chAccess), .ch_hit(chHit), .ch_miss(chMiss),
        .ch_busy(chBusy), .commit_valid(commitValid), .halt(halt), .clear(clear),
        .rd_ch(rdCh), .rd_sel(rdSel), .rd_data(rdDataB), .state_o(stateB),
        .done_pulse(doneB), .proto_err(perrB)
    );

    typedef struct {
        logic [CW-1:0]  rdA, rdB;
        logic [1:0]     stA, stB;
        logic           doneA, doneB;
        logic [NCH-1:0] perrA, perrB;
    } expect_t;

    expect_t expQ[$];

    int vectorCount   = 0;
    int miscompares   = 0;

    // Reference model: plain counts, and "cycles since last reference point"
    // for the watchdog rather than a down-counter.
    int             mCnt  [2][NCH][4];
    int             mIdle [2];
    int             mSt   [2];
    logic           mDone [2];
    logic [NCH-1:0] mPerr [2];
    int             mRd   [2];

    function automatic int satInc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic modelStep(input int i);
        int limit;
        limit = (i == 0) ? TA : TB;
        if (rst) begin
            for (int c = 0; c < NCH; c++) for (int s = 0; s < 4; s++) mCnt[i][c][s] = 0;
            mIdle[i] = 0; mSt[i] = 0; mDone[i] = 1'b0; mPerr[i] = '0; mRd[i] = 0;
        end else begin
            mRd[i] = (rdCh < NCH) ? mCnt[i][rdCh][rdSel] : 0;
            mDone[i] = 1'b0;
            if (clear) begin
                for (int c = 0; c < NCH; c++) for (int s = 0; s < 4; s++) mCnt[i][c][s] = 0;
                mIdle[i] = 0; mSt[i] = 0; mPerr[i] = '0;
            end else begin
                mPerr[i] = mPerr[i] | (chHit & chMiss);
                if (mSt[i] == 0) begin
                    for (int c = 0; c < NCH; c++) begin
                        if (chHit[c] && !chMiss[c]) mCnt[i][c][0] = satInc(mCnt[i][c][0]);
                        if (chMiss[c] && !chHit[c]) mCnt[i][c][1] = satInc(mCnt[i][c][1]);
                        if (chAccess[c])            mCnt[i][c][2] = satInc(mCnt[i][c][2]);
                        if (chBusy[c])              mCnt[i][c][3] = satInc(mCnt[i][c][3]);
                    end
                    if (i == 1 && commitValid) mIdle[i] = 0;
                    else                       mIdle[i] = mIdle[i] + 1;
                    if (halt) begin
                        mSt[i] = 1; mDone[i] = 1'b1;
                    end else if (mIdle[i] >= limit) begin
                        mSt[i] = 2; mDone[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic h, input logic cv,
                                 input logic [NCH-1:0] acc, input logic [NCH-1:0] hit,
                                 input logic [NCH-1:0] miss, input logic [NCH-1:0] busy,
                                 input logic [1:0] rch, input logic [1:0] rsel);
        expect_t e;
        @(negedge clk);
        rst = r; clear = c; halt = h; commitValid = cv;
        chAccess = acc; chHit = hit; chMiss = miss; chBusy = busy;
        rdCh = rch; rdSel = rsel;
        modelStep(0);
        modelStep(1);
        e.rdA = CW'(mRd[0]);   e.rdB = CW'(mRd[1]);
        e.stA = 2'(mSt[0]);    e.stB = 2'(mSt[1]);
        e.doneA = mDone[0];    e.doneB = mDone[1];
        e.perrA = mPerr[0];    e.perrB = mPerr[1];
        expQ.push_back(e);
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("rd_data A",    32'(rdDataA), 32'(e.rdA));
        checkField("state A",      32'(stateA),  32'(e.stA));
        checkField("done_pulse A", 32'(doneA),   32'(e.doneA));
        checkField("proto_err A",  32'(perrA),   32'(e.perrA));
        checkField("rd_data B",    32'(rdDataB), 32'(e.rdB));
        checkField("state B",      32'(stateB),  32'(e.stB));
        checkField("done_pulse B", 32'(doneB),   32'(e.doneB));
        checkField("proto_err B",  32'(perrB),   32'(e.perrB));
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        logic [NCH-1:0] z;
        z = '0;
        rst = 1'b1; clear = 1'b0; halt = 1'b0; commitValid = 1'b0;
        chAccess = '0; chHit = '0; chMiss = '0; chBusy = '0; rdCh = '0; rdSel = '0;

        repeat (2) applyStimulus(1, 0, 0, 0, z, z, z, z, 0, 0);

        // Five accesses on ch0: three hits then two misses.
        for (int k = 0; k < 5; k++)
            applyStimulus(0, 0, 0, 1, 3'b001, (k < 3) ? 3'b001 : z, (k >= 3) ? 3'b001 : z, z, 0, 0);
        for (int c = 0; c < 3; c++)
            for (int s = 0; s < 4; s++)
                applyStimulus(0, 0, 0, 0, z, z, z, z, 2'(c), 2'(s));
        // Both watchdogs run out here; later strobes must not move the counters.
        for (int k = 0; k < 12; k++)
            applyStimulus(0, 0, 0, 0, 3'b111, 3'b001, z, 3'b111, 0, 2);

        // Busy saturation with commits keeping the relative watchdog alive.
        applyStimulus(0, 1, 0, 0, z, z, z, z, 0, 0);
        for (int k = 0; k < 300; k++)
            applyStimulus(0, 0, 0, 1, z, z, z, 3'b100, 2, 3);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 0, 0, 0, z, z, z, z, 2, 2'(k + 1));

        // Periodic commits, then silence until the relative watchdog expires.
        applyStimulus(0, 1, 0, 0, z, z, z, z, 0, 0);
        for (int k = 0; k < 50; k++)
            applyStimulus(0, 0, 0, (k % 6) == 5, z, z, z, z, 0, 2);
        for (int k = 0; k < 12; k++)
            applyStimulus(0, 0, 0, 0, z, z, z, z, 0, 2);

        // Halt lands on the same edge as the absolute watchdog expiry.
        applyStimulus(0, 1, 0, 0, z, z, z, z, 0, 0);
        for (int k = 0; k < 19; k++)
            applyStimulus(0, 0, 0, 0, z, z, z, z, 0, 0);
        applyStimulus(0, 0, 1, 0, z, z, z, z, 0, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 0, 0, 0, z, z, z, z, 0, 0);

        // Hit+miss collision on ch1, first under clear, then without.
        applyStimulus(0, 1, 0, 1, 3'b010, 3'b010, 3'b010, z, 1, 0);
        applyStimulus(0, 0, 0, 1, 3'b010, 3'b010, 3'b010, z, 1, 0);
        for (int s = 0; s < 4; s++)
            applyStimulus(0, 0, 0, 1, z, z, z, z, 1, 2'(s));
        applyStimulus(0, 0, 0, 1, z, z, z, z, 3, 2);
        applyStimulus(0, 0, 0, 1, z, z, z, z, 3, 0);

        // Randomized traffic with occasional clear, halt and reset.
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                          NCH'($urandom), NCH'($urandom), NCH'($urandom), NCH'($urandom),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        applyStimulus(1, 0, 0, 0, z, z, z, z, 0, 0);
        applyStimulus(0, 0, 0, 0, z, z, z, z, 0, 0);

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
